// File: rtl/johnson_digit_capture.sv
// ============================================================================
// Module   : johnson_digit_capture
// Captures three asynchronous Johnson-coded digits and holds them as BCD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module johnson_digit_capture #(
  parameter int pPERIOD = 16,
  parameter int pSTABLE = 2,
  parameter int pRETRY  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hold,
  input  logic [4:0]  i_100,
  input  logic [4:0]  i_010,
  input  logic [4:0]  i_001,
  output logic [11:0] o_bcd,
  output logic        o_valid,
  output logic        o_miss,
  output logic [7:0]  o_miss_cnt,
  output logic        o_err
);

  localparam int c_CW = $clog2(pPERIOD + 1);
  localparam int c_SW = $clog2(pSTABLE + 1);
  localparam int c_RW = $clog2(pRETRY + 1);

  localparam logic [1:0] c_WAIT   = 2'd0;
  localparam logic [1:0] c_SAMPLE = 2'd1;
  localparam logic [1:0] c_UPDATE = 2'd2;

  function automatic logic f_legal(input logic [4:0] code);
    case (code)
      5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: f_legal = 1'b1;
      default:                                          f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_digit(input logic [4:0] code);
    case (code)
      5'b00001: f_digit = 4'd1;
      5'b00011: f_digit = 4'd2;
      5'b00111: f_digit = 4'd3;
      5'b01111: f_digit = 4'd4;
      5'b11111: f_digit = 4'd5;
      5'b11110: f_digit = 4'd6;
      5'b11100: f_digit = 4'd7;
      5'b11000: f_digit = 4'd8;
      5'b10000: f_digit = 4'd9;
      default:  f_digit = 4'd0;
    endcase
  endfunction

  logic [14:0]     sync1_q, sync2_q;
  logic [1:0]      state_q, state_d;
  logic [c_CW-1:0] cnt_q, cnt_d;
  logic [c_SW-1:0] stable_q, stable_d;
  logic [c_RW-1:0] retry_q, retry_d;
  logic [14:0]     r_q, r_d;
  logic            first_q, first_d;
  logic [11:0]     bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic            miss_q, miss_d;
  logic [7:0]      miss_cnt_q, miss_cnt_d;
  logic            err_q, err_d;
  logic            w_legal, w_abort, w_mis;

  assign w_legal = f_legal(sync2_q[14:10]) & f_legal(sync2_q[9:5]) & f_legal(sync2_q[4:0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= c_WAIT;
    else       state_q <= state_d;
  end

  // First SAMPLE cycle always reloads R; later cycles reload only on mismatch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    r_d      = r_q;
    first_d  = 1'b0;
    w_abort  = 1'b0;
    w_mis    = 1'b0;
    case (state_q)
      c_WAIT: begin
        if (!i_hold) begin
          if (cnt_q == c_CW'(pPERIOD - 1)) begin
            state_d  = c_SAMPLE;
            cnt_d    = '0;
            stable_d = '0;
            retry_d  = '0;
            first_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      c_SAMPLE: begin
        w_mis = !first_q && !(sync2_q == r_q && w_legal);
        if (first_q || w_mis) begin
          r_d      = sync2_q;
          stable_d = w_legal ? c_SW'(1) : '0;
          if (w_mis) retry_d = retry_q + 1'b1;
        end else begin
          stable_d = stable_q + 1'b1;
        end
        if (stable_d == c_SW'(pSTABLE)) begin
          state_d = c_UPDATE;
        end else if (w_mis && retry_d == c_RW'(pRETRY)) begin
          state_d = c_WAIT;
          w_abort = 1'b1;
        end
      end
      c_UPDATE: state_d = c_WAIT;
      default:  state_d = c_WAIT;
    endcase
  end

  always_comb begin
    valid_d    = (state_q == c_UPDATE);
    bcd_d      = valid_d ? {f_digit(r_q[14:10]), f_digit(r_q[9:5]), f_digit(r_q[4:0])} : bcd_q;
    miss_d     = w_abort;
    miss_cnt_d = (w_abort && miss_cnt_q != 8'hFF) ? miss_cnt_q + 8'd1 : miss_cnt_q;
    err_d      = err_q | ((state_q == c_SAMPLE) && !w_legal);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      stable_q   <= '0;
      retry_q    <= '0;
      r_q        <= '0;
      first_q    <= 1'b0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      miss_q     <= 1'b0;
      miss_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= {i_100, i_010, i_001};
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      retry_q    <= retry_d;
      r_q        <= r_d;
      first_q    <= first_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      miss_q     <= miss_d;
      miss_cnt_q <= miss_cnt_d;
      err_q      <= err_d;
    end
  end

  assign o_bcd      = bcd_q;
  assign o_valid    = valid_q;
  assign o_miss     = miss_q;
  assign o_miss_cnt = miss_cnt_q;
  assign o_err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_johnson_digit_capture.sv
// ============================================================================
// Module   : tb_johnson_digit_capture
// Directed scenario bench for johnson_digit_capture with default parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_johnson_digit_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic [4:0]  d100 = 5'b0, d010 = 5'b0, d001 = 5'b0;
  logic [11:0] bcd;
  logic        valid, miss, err;
  logic [7:0]  miss_cnt;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  johnson_digit_capture dut (
    .i_clk(clk), .i_rst(rst), .i_hold(hold),
    .i_100(d100), .i_010(d010), .i_001(d001),
    .o_bcd(bcd), .o_valid(valid), .o_miss(miss),
    .o_miss_cnt(miss_cnt), .o_err(err)
  );

  task automatic tick;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset;
    rst = 1'b1; hold = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; cyc = 0;
  endtask

  task automatic test_reset;
    d100 = 5'b00001; d010 = 5'b00011; d001 = 5'b00111;
    do_reset();
    n_tests++; if (bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %h, expected 000", bcd); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid); end
    n_tests++; if (miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %b, expected 0", miss); end
    n_tests++; if (miss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_miss_cnt: got %0d, expected 0", miss_cnt); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
  endtask

  task automatic test_basic;
    int v1 = -1, v2 = -1, nv = 0, overlap = 0;
    logic [11:0] b19 = 12'hFFF;
    d100 = 5'b00001; d010 = 5'b00011; d001 = 5'b00111;
    do_reset();
    repeat (40) begin
      tick();
      if (valid) begin nv++; if (v1 < 0) v1 = cyc; else if (v2 < 0) v2 = cyc; end
      if (valid && miss) overlap++;
      if (cyc == 19) b19 = bcd;
    end
    n_tests++; if (v1 !== 19) begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d, expected 19", v1); end
    n_tests++; if (v2 !== 38) begin n_fail++; $display("FAIL basic_second_valid: got cycle %0d, expected 38", v2); end
    n_tests++; if (nv !== 2) begin n_fail++; $display("FAIL basic_valid_count: got %0d, expected 2", nv); end
    n_tests++; if (b19 !== 12'h123) begin n_fail++; $display("FAIL basic_bcd: got %h, expected 123", b19); end
    n_tests++; if (miss_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_miss_cnt: got %0d, expected 0", miss_cnt); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b, expected 0", err); end
    n_tests++; if (overlap !== 0) begin n_fail++; $display("FAIL basic_overlap: got %0d, expected 0", overlap); end
  endtask

  task automatic test_wrap;
    logic [11:0] b19 = 12'hFFF, b38 = 12'hFFF;
    logic v38 = 1'b0;
    d100 = 5'b10000; d010 = 5'b10000; d001 = 5'b10000;
    do_reset();
    repeat (38) begin
      tick();
      if (cyc == 19) begin
        b19 = bcd;
        d100 = 5'b00000; d010 = 5'b00000; d001 = 5'b00000;
      end
      if (cyc == 38) begin b38 = bcd; v38 = valid; end
    end
    n_tests++; if (b19 !== 12'h999) begin n_fail++; $display("FAIL wrap_bcd_999: got %h, expected 999", b19); end
    n_tests++; if (v38 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid38: got %b, expected 1", v38); end
    n_tests++; if (b38 !== 12'h000) begin n_fail++; $display("FAIL wrap_bcd_000: got %h, expected 000", b38); end
  endtask

  task automatic test_miss;
    int m1 = -1, m2 = -1, nv = 0;
    logic [7:0] cnt44 = 8'hFF;
    d100 = 5'b00001; d010 = 5'b00011; d001 = 5'b00111;
    do_reset();
    repeat (70) begin
      tick();
      if (cyc > 19 && valid) nv++;
      if (miss) begin if (m1 < 0) m1 = cyc; else if (m2 < 0) m2 = cyc; end
      if (cyc == 44) cnt44 = miss_cnt;
      if (cyc == 19) d001 = 5'b00000;
      else if (cyc > 19) d001 = (d001 == 5'b00000) ? 5'b00001 : 5'b00000;
    end
    n_tests++; if (m1 !== 44) begin n_fail++; $display("FAIL miss_first: got cycle %0d, expected 44", m1); end
    n_tests++; if (cnt44 !== 8'd1) begin n_fail++; $display("FAIL miss_cnt_1: got %0d, expected 1", cnt44); end
    n_tests++; if (m2 !== 69) begin n_fail++; $display("FAIL miss_second: got cycle %0d, expected 69", m2); end
    n_tests++; if (miss_cnt !== 8'd2) begin n_fail++; $display("FAIL miss_cnt_2: got %0d, expected 2", miss_cnt); end
    n_tests++; if (bcd !== 12'h123) begin n_fail++; $display("FAIL miss_bcd_hold: got %h, expected 123", bcd); end
    n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL miss_no_valid: got %0d pulses, expected 0", nv); end
  endtask

  task automatic test_illegal;
    int v1 = -1, m1 = -1;
    logic err17 = 1'b0, err44 = 1'b0;
    logic [11:0] b43 = 12'hFFF, b44 = 12'hFFF;
    d100 = 5'b00001; d010 = 5'b01010; d001 = 5'b00111;
    do_reset();
    repeat (45) begin
      tick();
      if (valid && v1 < 0) v1 = cyc;
      if (miss && m1 < 0) m1 = cyc;
      if (cyc == 17) err17 = err;
      if (cyc == 26) d010 = 5'b00011;
      if (cyc == 43) b43 = bcd;
      if (cyc == 44) begin b44 = bcd; err44 = err; end
    end
    n_tests++; if (err17 !== 1'b1) begin n_fail++; $display("FAIL illegal_err_set: got %b, expected 1", err17); end
    n_tests++; if (m1 !== 25) begin n_fail++; $display("FAIL illegal_abort: got cycle %0d, expected 25", m1); end
    n_tests++; if (b43 !== 12'h000) begin n_fail++; $display("FAIL illegal_no_update: got %h, expected 000", b43); end
    n_tests++; if (v1 !== 44) begin n_fail++; $display("FAIL illegal_recover_valid: got cycle %0d, expected 44", v1); end
    n_tests++; if (b44 !== 12'h123) begin n_fail++; $display("FAIL illegal_recover_bcd: got %h, expected 123", b44); end
    n_tests++; if (err44 !== 1'b1) begin n_fail++; $display("FAIL illegal_err_sticky: got %b, expected 1", err44); end
  endtask

  task automatic test_hold;
    int v1 = -1;
    d100 = 5'b00001; d010 = 5'b00011; d001 = 5'b00111;
    do_reset();
    repeat (60) begin
      tick();
      if (valid && v1 < 0) v1 = cyc;
      if (cyc == 5) hold = 1'b1;
      if (cyc == 45) hold = 1'b0;
    end
    n_tests++; if (v1 !== 59) begin n_fail++; $display("FAIL hold_valid: got cycle %0d, expected 59", v1); end
  endtask

  task automatic test_reset_update;
    int v1 = -1;
    logic v0, m0;
    logic [11:0] b0;
    d100 = 5'b00001; d010 = 5'b00011; d001 = 5'b00111;
    do_reset();
    repeat (18) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cyc = 0;
    v0 = valid; m0 = miss; b0 = bcd;
    repeat (25) begin
      tick();
      if (valid && v1 < 0) v1 = cyc;
    end
    n_tests++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL rstupd_no_valid: got %b, expected 0", v0); end
    n_tests++; if (m0 !== 1'b0) begin n_fail++; $display("FAIL rstupd_no_miss: got %b, expected 0", m0); end
    n_tests++; if (b0 !== 12'h000) begin n_fail++; $display("FAIL rstupd_bcd: got %h, expected 000", b0); end
    n_tests++; if (v1 !== 19) begin n_fail++; $display("FAIL rstupd_next_valid: got cycle %0d, expected 19", v1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_miss();
    test_illegal();
    test_hold();
    test_reset_update();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
